// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: debounce state encoding and divider/debounce sizing helpers for the LED step tick generator.
package led_ctrl_pkg;
  typedef enum logic [1:0] {LO_STABLE, CHK_HI, HI_STABLE, CHK_LO} db_state_t;
  function automatic int calc_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction
  function automatic int calc_db_cyc(input int clk_hz, input int debounce_ms);
    return (clk_hz / 1000) * debounce_ms;
  endfunction
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int DEF_DIV    = calc_div(50_000_000, 4);
  localparam int DEF_DIV_W  = cnt_w(DEF_DIV);
  localparam int DEF_DB_CYC = calc_db_cyc(50_000_000, 10);
  localparam int DEF_DB_W   = cnt_w(DEF_DB_CYC);
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-FF synchroniser plus 4-state debounce FSM; registered level and 1-cycle rise pulse.
module sw_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DB_CYC = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_level,
  output logic rise_pulse
);
  localparam int W = cnt_w(DB_CYC);
  localparam logic [W-1:0] LAST = W'(DB_CYC - 1);
  logic r_s1, r_s2;
  db_state_t r_state;
  logic [W-1:0] r_cnt;
  logic w_done;
  assign w_done = (r_cnt == LAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_state    <= LO_STABLE;
      r_cnt      <= '0;
      sw_level   <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      r_s1       <= sw;
      r_s2       <= r_s1;
      rise_pulse <= 1'b0;
      case (r_state)
        LO_STABLE: if (r_s2) begin
          r_state <= CHK_HI;
          r_cnt   <= '0;
        end
        CHK_HI: if (!r_s2) r_state <= LO_STABLE;
          else if (w_done) begin
            r_state    <= HI_STABLE;
            sw_level   <= 1'b1;
            rise_pulse <= 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        HI_STABLE: if (!r_s2) begin
          r_state <= CHK_LO;
          r_cnt   <= '0;
        end
        CHK_LO: if (r_s2) r_state <= HI_STABLE;
          else if (w_done) begin
            r_state  <= LO_STABLE;
            sw_level <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= LO_STABLE;
      endcase
    end
  end
endmodule

// File: rtl/led_step_tick_gen.sv
// led_step_tick_gen: debounced run/pause switch driving a step-rate prescaler with restart pulse.
// Optional LED_STEP_FAST_EN adds a `fast` input that shortens the step period to DIV/4.
module led_step_tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int STEP_HZ     = 4,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
`ifdef LED_STEP_FAST_EN
  input  logic fast,
`endif
  output logic step,
  output logic restart,
  output logic sw_level
);
  localparam int DIV    = calc_div(CLK_HZ, STEP_HZ);
  localparam int DB_CYC = calc_db_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int DW     = cnt_w(DIV);
  localparam logic [DW-1:0] TERM_SLOW = DW'(DIV - 1);
  localparam logic [DW-1:0] TERM_FAST = DW'(DIV / 4 - 1);
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_term;
`ifdef LED_STEP_FAST_EN
  assign w_term = fast ? TERM_FAST : TERM_SLOW;
`else
  assign w_term = TERM_SLOW;
`endif
  sw_debounce #(.DB_CYC(DB_CYC)) u_db (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .sw_level   (sw_level),
    .rise_pulse (restart)
  );
  // The restart cycle is tick 0 of the new period, so the first step lands DIV cycles after restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      step  <= 1'b0;
    end else if (restart) begin
      r_div <= DW'(1);
      step  <= 1'b0;
    end else if (sw_level && r_div >= w_term) begin
      r_div <= '0;
      step  <= 1'b1;
    end else begin
      r_div <= sw_level ? r_div + 1'b1 : r_div;
      step  <= 1'b0;
    end
  end
endmodule
